// File: rtl/chip_link_tx_pkg.sv
// Shared definitions for the chip-to-chip link (transmitter and receiver).
// Holds default widths, the 2-bit FSM state encoding and the flit parity
// helper so both ends of the link agree on what "even parity" means.
package pcss_link_pkg;

    localparam int DEF_PKT_WIDTH      = 64;
    localparam int DEF_CHIPDATA_WIDTH = 16;

    // Widest flit the parity helper accepts; narrower flits are zero-extended,
    // which leaves the XOR-reduce unchanged.
    localparam int MAX_FLIT_W = 64;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DRIVE   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    // Even parity bit: set when the flit has an odd number of ones, so flit
    // plus parity always carries an even count.
    function automatic logic flit_par(input logic [MAX_FLIT_W-1:0] flit);
        return ^flit;
    endfunction

endpackage

// File: rtl/chip_link_tx_if.sv
// Bundle of the router-side packet handshake and the chip-link flit
// handshake for one mesh direction.
//   master : the transmitter (drives pkt_ready, send_data_*, link_fail, busy)
//   slave  : the surrounding router / neighbour receiver
interface chip_link_tx_if
    import pcss_link_pkg::*;
#(
    parameter int PKT_WIDTH      = DEF_PKT_WIDTH,
    parameter int CHIPDATA_WIDTH = DEF_CHIPDATA_WIDTH
) ();

    logic [PKT_WIDTH-1:0]      pkt_in;
    logic                      pkt_valid;
    logic                      pkt_ready;
    logic [CHIPDATA_WIDTH-1:0] send_data_out;
    logic                      send_data_valid;
    logic                      send_data_par;
    logic                      send_data_ready;
    logic                      send_data_err;
    logic                      link_fail;
    logic                      busy;

    modport master (
        input  pkt_in, pkt_valid, send_data_ready, send_data_err,
        output pkt_ready, send_data_out, send_data_valid, send_data_par,
               link_fail, busy
    );

    modport slave (
        output pkt_in, pkt_valid, send_data_ready, send_data_err,
        input  pkt_ready, send_data_out, send_data_valid, send_data_par,
               link_fail, busy
    );

endinterface

// File: rtl/chip_link_tx.sv
// Off-chip link transmitter for one mesh direction.
// Takes a PKT_WIDTH packet from the router and sends it MSB-first as
// PKT_WIDTH/CHIPDATA_WIDTH flits over a four-phase valid/ready handshake
// with per-flit even parity. A flit acked with err is resent up to
// MAX_RETRY times; after that the packet is dropped and link_fail pulses.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   link       : chip_link_tx_if.master (pkt_* router handshake,
//                send_data_* flit handshake, link_fail, busy)
// All outputs are registered.
module chip_link_tx
    import pcss_link_pkg::*;
#(
    parameter int PKT_WIDTH      = DEF_PKT_WIDTH,
    parameter int CHIPDATA_WIDTH = DEF_CHIPDATA_WIDTH,
    parameter int MAX_RETRY      = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    chip_link_tx_if.master link
);

    localparam int FLITS = PKT_WIDTH / CHIPDATA_WIDTH;
    localparam int CNT_W = (FLITS > 1) ? $clog2(FLITS) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CNT_W-1:0] LAST_FLIT = CNT_W'(FLITS - 1);
    localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(MAX_RETRY);

    logic [1:0]           state_q, state_d;
    logic [PKT_WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]     flit_cnt_q;
    logic [RTY_W-1:0]     retry_q;
    logic                 err_q;

    logic par_q, par_d;
    logic valid_q, valid_d;
    logic ready_q, ready_d;
    logic busy_q, busy_d;
    logic fail_q, fail_d;

    // Decoded events for the current cycle.
    logic accept, ack, release_done;
    logic advance, finish, resend, drop;

    always_comb begin
        accept       = (state_q == ST_IDLE) && ready_q && link.pkt_valid;
        ack          = (state_q == ST_DRIVE) && link.send_data_ready;
        release_done = (state_q == ST_RELEASE) && !link.send_data_ready;
        advance      = release_done && !err_q && (flit_cnt_q != LAST_FLIT);
        finish       = release_done && !err_q && (flit_cnt_q == LAST_FLIT);
        resend       = release_done &&  err_q && (retry_q != RTY_LIMIT);
        drop         = release_done &&  err_q && (retry_q == RTY_LIMIT);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (accept) state_d = ST_DRIVE;
            ST_DRIVE:   if (ack)    state_d = ST_RELEASE;
            ST_RELEASE: if (release_done)
                            state_d = (advance || resend) ? ST_DRIVE : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values. The flit on the wire is always the top
    // slice of the shift register, so a retry simply leaves it untouched.
    always_comb begin
        shreg_d = shreg_q;
        if (accept)       shreg_d = link.pkt_in;
        else if (advance) shreg_d = shreg_q << CHIPDATA_WIDTH;

        par_d   = flit_par(MAX_FLIT_W'(shreg_d[PKT_WIDTH-1 -: CHIPDATA_WIDTH]));
        valid_d = (state_d == ST_DRIVE);
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
        fail_d  = drop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q    <= '0;
            par_q      <= 1'b0;
            valid_q    <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            fail_q     <= 1'b0;
            flit_cnt_q <= '0;
            retry_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            par_q   <= par_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            fail_q  <= fail_d;

            if (accept)       flit_cnt_q <= '0;
            else if (advance) flit_cnt_q <= flit_cnt_q + CNT_W'(1);

            if (accept || advance) retry_q <= '0;
            else if (resend)       retry_q <= retry_q + RTY_W'(1);

            // err only means something alongside ready.
            if (ack) err_q <= link.send_data_err;
        end
    end

    assign link.send_data_out   = shreg_q[PKT_WIDTH-1 -: CHIPDATA_WIDTH];
    assign link.send_data_par   = par_q;
    assign link.send_data_valid = valid_q;
    assign link.pkt_ready       = ready_q;
    assign link.busy            = busy_q;
    assign link.link_fail       = fail_q;

endmodule

// File: tb/tb_chip_link_tx.sv
// Bench for chip_link_tx: a registered four-phase receiver model fed from a
// per-phase plan queue, a flit monitor checking against a scoreboard queue,
// a table of packet vectors plus hand sequences for reset and back-to-back.
module tb_chip_link_tx;

    localparam int MAX_RETRY = 3;

    typedef struct {
        logic [63:0] pkt;
        logic [3:0]  par;        // expected parity, first flit in bit 3
        int          err_flit;   // flit index acked with err (-1 none)
        int          err_cnt;    // how many consecutive err acks on it
        int          stall_flit; // flit index whose first ack is delayed
        int          stall_cyc;
        int          phases;     // expected valid phases
        bit          fail;       // expect link_fail pulse
        int          lat;        // accept -> pkt_ready high, in cycles
    } vec_t;

    typedef struct { logic [15:0] data; logic par; } flit_t;
    typedef struct { int stall; bit err; } plan_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    chip_link_tx_if #(.PKT_WIDTH(64), .CHIPDATA_WIDTH(16)) link ();

    chip_link_tx #(.PKT_WIDTH(64), .CHIPDATA_WIDTH(16), .MAX_RETRY(MAX_RETRY)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .link (link)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int phase_cnt = 0;
    int fail_cnt = 0;
    int stab_viol = 0;
    int proto_viol = 0;
    bit junk_err = 0;

    flit_t exp_q[$];
    plan_t plan_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Receiver with registered ready: reacts one edge after seeing valid.
    initial begin
        logic  v;
        plan_t cfg;
        bit    have_cfg;
        int    stall_cnt;
        have_cfg = 0;
        stall_cnt = 0;
        cfg = '{0, 1'b0};
        link.send_data_ready = 1'b0;
        link.send_data_err = 1'b0;
        forever begin
            @(negedge clk);
            v = link.send_data_valid;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                link.send_data_ready = 1'b0;
                link.send_data_err = 1'b0;
                have_cfg = 0;
            end else if (v && !link.send_data_ready) begin
                if (!have_cfg) begin
                    cfg = (plan_q.size() != 0) ? plan_q.pop_front() : '{0, 1'b0};
                    have_cfg = 1;
                    stall_cnt = 0;
                end
                if (stall_cnt < cfg.stall) begin
                    stall_cnt++;
                    link.send_data_err = junk_err;
                end else begin
                    link.send_data_ready = 1'b1;
                    link.send_data_err = cfg.err;
                    have_cfg = 0;
                end
            end else if (!v && link.send_data_ready) begin
                link.send_data_ready = 1'b0;
                link.send_data_err = junk_err;
            end
        end
    end

    // Flit monitor: every rising valid is one phase, compared to the scoreboard.
    initial begin
        logic        prev_v;
        flit_t       cur;
        prev_v = 1'b0;
        cur = '{16'h0, 1'b0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
            end else begin
                if (link.link_fail) fail_cnt++;
                if (link.send_data_valid && !prev_v) begin
                    phase_cnt++;
                    if (link.send_data_ready) proto_viol++;
                    chk("flit_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        cur = exp_q.pop_front();
                        chk("flit_data", 64'(link.send_data_out), 64'(cur.data));
                        chk("flit_par", 64'(link.send_data_par), 64'(cur.par));
                    end
                end else if (link.send_data_valid && prev_v) begin
                    if (link.send_data_out !== cur.data || link.send_data_par !== cur.par)
                        stab_viol++;
                end
                prev_v = link.send_data_valid;
            end
        end
    end

    // Push the receiver plan and expected flits for one packet.
    task automatic load_vec(input vec_t v);
        bit e;
        for (int i = 0; i < 4; i++) begin
            for (int r = 0; r <= MAX_RETRY; r++) begin
                e = (i == v.err_flit) && (r < v.err_cnt);
                exp_q.push_back('{v.pkt[63-16*i -: 16], v.par[3-i]});
                plan_q.push_back('{(i == v.stall_flit && r == 0) ? v.stall_cyc : 0, e});
                if (e && r == MAX_RETRY) return;
                if (!e) break;
            end
        end
    endtask

    function automatic vec_t plain_vec(input logic [63:0] pkt);
        vec_t v;
        v = '{pkt, 4'b0, -1, 0, -1, 0, 4, 1'b0, 16};
        for (int i = 0; i < 4; i++) v.par[3-i] = ^pkt[63-16*i -: 16];
        return v;
    endfunction

    task automatic offer(input logic [63:0] pkt, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        while (!link.pkt_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("offer_ready", 64'(link.pkt_ready), 64'd1);
        link.pkt_in = pkt;
        link.pkt_valid = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        link.pkt_valid = 1'b0;
        link.pkt_in = {$urandom, $urandom};
    endtask

    task automatic wait_ready(input int budget, output int at);
        int n;
        n = 0;
        @(negedge clk);
        while (!link.pkt_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", 64'(link.pkt_ready), 64'd1);
        at = cyc;
    endtask

    vec_t vecs[5];

    initial begin
        int acc, done_at, ph0, fl0, sv0, pv0, acc_b, n;
        vec_t v;

        vecs[0] = '{64'h0001_FFFF_8000_7FFE, 4'b1010, -1, 0, -1,  0, 4, 1'b0, 16};
        vecs[1] = '{64'h0001_FFFF_8000_7FFE, 4'b1010, -1, 0,  1, 50, 4, 1'b0, 66};
        vecs[2] = '{64'h0001_FFFF_8000_7FFE, 4'b1010,  2, 1, -1,  0, 5, 1'b0, 20};
        vecs[3] = '{64'h0001_FFFF_8000_7FFE, 4'b1010,  0, 4, -1,  0, 4, 1'b1, 16};
        vecs[4] = '{64'hA5A5_0000_0000_0001, 4'b0001, -1, 0, -1,  0, 4, 1'b0, 16};

        link.pkt_in = '0;
        link.pkt_valid = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(link.send_data_valid), 64'd0);
        chk("rst_data", 64'(link.send_data_out), 64'd0);
        chk("rst_par", 64'(link.send_data_par), 64'd0);
        chk("rst_pkt_ready", 64'(link.pkt_ready), 64'd0);
        chk("rst_link_fail", 64'(link.link_fail), 64'd0);
        chk("rst_busy", 64'(link.busy), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("pkt_ready_before_edge", 64'(link.pkt_ready), 64'd0);
        @(negedge clk);
        chk("pkt_ready_first_edge", 64'(link.pkt_ready), 64'd1);

        // Table vectors.
        for (int k = 0; k < 5; k++) begin
            v = vecs[k];
            ph0 = phase_cnt; fl0 = fail_cnt; sv0 = stab_viol; pv0 = proto_viol;
            load_vec(v);
            offer(v.pkt, acc);
            chk($sformatf("v%0d_valid_after_accept", k), 64'(link.send_data_valid), 64'd1);
            chk($sformatf("v%0d_busy", k), 64'(link.busy), 64'd1);
            chk($sformatf("v%0d_pkt_ready_low", k), 64'(link.pkt_ready), 64'd0);
            wait_ready(400, done_at);
            chk($sformatf("v%0d_latency", k), 64'(done_at - acc), 64'(v.lat));
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_phases", k), 64'(phase_cnt - ph0), 64'(v.phases));
            chk($sformatf("v%0d_link_fail_cycles", k), 64'(fail_cnt - fl0), 64'(v.fail));
            chk($sformatf("v%0d_scoreboard_empty", k), 64'(exp_q.size()), 64'd0);
            chk($sformatf("v%0d_stable", k), 64'(stab_viol - sv0), 64'd0);
            chk($sformatf("v%0d_four_phase", k), 64'(proto_viol - pv0), 64'd0);
            chk($sformatf("v%0d_busy_done", k), 64'(link.busy), 64'd0);
            plan_q.delete();
        end

        // Reset in the middle of flit 2.
        v = plain_vec(64'h1234_5678_9ABC_DEF0);
        v.stall_flit = 1;
        v.stall_cyc = 20;
        ph0 = phase_cnt;
        load_vec(v);
        offer(v.pkt, acc);
        n = 0;
        while (phase_cnt - ph0 < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reset_reached_flit2", 64'(phase_cnt - ph0), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_valid", 64'(link.send_data_valid), 64'd0);
        chk("mid_reset_data", 64'(link.send_data_out), 64'd0);
        chk("mid_reset_busy", 64'(link.busy), 64'd0);
        chk("mid_reset_pkt_ready", 64'(link.pkt_ready), 64'd0);
        exp_q.delete();
        plan_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_pkt_ready", 64'(link.pkt_ready), 64'd1);
        ph0 = phase_cnt;
        repeat (10) @(negedge clk);
        chk("post_reset_no_stale_flit", 64'(phase_cnt - ph0), 64'd0);
        chk("post_reset_valid_low", 64'(link.send_data_valid), 64'd0);

        // Back-to-back with pkt_valid held high; junk err while ready is low.
        junk_err = 1;
        ph0 = phase_cnt; fl0 = fail_cnt; sv0 = stab_viol; pv0 = proto_viol;
        load_vec(plain_vec(64'h0123_4567_89AB_CDEF));
        load_vec(plain_vec(64'hFEDC_BA98_7654_3210));
        @(negedge clk);
        link.pkt_in = 64'h0123_4567_89AB_CDEF;
        link.pkt_valid = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        link.pkt_in = 64'hFEDC_BA98_7654_3210;
        n = 0;
        @(negedge clk);
        while (!link.pkt_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        acc_b = cyc;
        link.pkt_valid = 1'b0;
        chk("b2b_accept_spacing", 64'(acc_b - acc), 64'd17);
        wait_ready(200, done_at);
        chk("b2b_second_latency", 64'(done_at - acc_b), 64'd16);
        repeat (3) @(negedge clk);
        chk("b2b_phases", 64'(phase_cnt - ph0), 64'd8);
        chk("b2b_scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("b2b_no_link_fail", 64'(fail_cnt - fl0), 64'd0);
        chk("b2b_stable", 64'(stab_viol - sv0), 64'd0);
        chk("b2b_four_phase", 64'(proto_viol - pv0), 64'd0);
        junk_err = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
